// File: rtl/adc_sample_sched.sv
// adc_sample_sched
//   Sequencer for the 8-bit serial ADC reader. It issues periodic conversion
//   requests, holds off for the ADC conversion time after each read, averages
//   2^AVG_LOG2 samples and offers each result on a valid/ready port. Lost
//   results and reads that never return done are flagged with sticky bits.
// Ports
//   clk, rst                 50 MHz clock, async active-high reset
//   en                       run periodic sampling
//   adc_start                one-cycle request to the reader (ISSUE state only)
//   adc_done, adc_data       reader completion pulse and sampled byte
//   res_data, res_valid,     averaged result, valid/ready handshake
//   res_ready
//   overrun, timeout         sticky error flags
//   clr_err                  clears the sticky flags (a same-cycle set wins)
module adc_sample_sched #(
  parameter int PERIOD   = 2500,
  parameter int TCONV    = 850,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       overrun,
  output logic       timeout,
  input  logic       clr_err
);

  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int PW = $clog2(PERIOD + 1);
  localparam int TW = $clog2(TCONV + 1);
  localparam int OW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, CONV, WAIT_TICK} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pcnt;   // cycles since the ISSUE cycle, minus one; saturates
  logic [TW-1:0] ccnt;   // cycles spent in CONV
  logic [OW-1:0] tcnt;   // cycles spent in WAIT_DONE
  logic [AW-1:0] accum;
  logic [CW-1:0] count;
  logic [AW-1:0] sum;
  logic          take, abort, tick, conv_end, load, drop_partial;

  assign take     = (state == WAIT_DONE) && adc_done;
  assign abort    = (state == WAIT_DONE) && !adc_done && (tcnt == OW'(TIMEOUT - 1));
  assign conv_end = (ccnt == TW'(TCONV - 1));
  // pcnt reads 0 in the cycle after ISSUE, so it shows PERIOD-2 one cycle
  // before the next ISSUE is due; deciding here yields exactly PERIOD spacing.
  assign tick     = (pcnt >= PW'(PERIOD - 2));
  assign sum      = accum + AW'(adc_data);
  assign load     = take && (count == CW'((1 << AVG_LOG2) - 1));
  assign drop_partial = (state == WAIT_TICK) && !en;
  assign adc_start = (state == ISSUE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (en) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (take || abort) state_nxt = CONV;
      CONV:      if (conv_end) state_nxt = WAIT_TICK;
      WAIT_TICK: if (!en) state_nxt = IDLE;
                 else if (tick) state_nxt = ISSUE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      ccnt      <= '0;
      tcnt      <= '0;
      accum     <= '0;
      count     <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ISSUE)            pcnt <= '0;
      else if (pcnt != PW'(PERIOD))  pcnt <= pcnt + 1'b1;

      if (state == ISSUE)            tcnt <= '0;
      else if (state == WAIT_DONE)   tcnt <= tcnt + 1'b1;

      if (state == CONV)             ccnt <= ccnt + 1'b1;
      else                           ccnt <= '0;

      // A finished average and a WAIT_TICK->IDLE exit both restart the average.
      if (load || drop_partial) begin
        accum <= '0;
        count <= '0;
      end else if (take) begin
        accum <= sum;
        count <= count + 1'b1;
      end

      if (load) res_data <= 8'(sum >> AVG_LOG2);
      res_valid <= load | (res_valid & ~res_ready);
      overrun   <= (load & res_valid & ~res_ready) | (overrun & ~clr_err);
      timeout   <= abort | (timeout & ~clr_err);
    end
  end

endmodule
